irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- five-source vectored interrupt controller for a Z80-style CPU.
//
// Source 0 is an internal 16-bit down-counting timer; sources 1-4 are the
// edge-detected peripheral request lines irq_src_i[3:0]. Priority is fixed,
// lowest index highest. During an interrupt-acknowledge cycle (M1 + IORQ)
// the block drives a vector {VBASE[7:4], idx, 0} on data_o and asserts
// vec_oe_o so the top-level data mux selects it.
//
// Ports
//   clk_i       system clock (CPU clock)
//   rst_n_i     asynchronous active-low reset
//   wr_n        CPU write strobe, active low
//   m1_n        CPU M1 cycle indicator, active low
//   ioreq_n     CPU IO request, active low
//   reg_addr_i  register select (cpu_addr[3:0])
//   data_i      CPU write data
//   irq_cs      register chip select from the address decoder
//   irq_src_i   peripheral level requests, sources 1-4
//   data_o      register read data, or vector while vec_oe_o=1
//   vec_oe_o    high during the acknowledge cycle
//   int_n       interrupt request to the CPU, active low (registered)
//
// Register map (reg_addr_i)
//   0 PENDING (W1C)  1 ENABLE (4:0 sources, 7 global)  2 VBASE
//   3 DIV_L  4 DIV_H (write loads counter)  5 TCTRL (bit0 run)
//   6 CNT_L (read latches CNT_H snapshot)   7 CNT_H snapshot
//   8-15 read 0x00, writes ignored
// -----------------------------------------------------------------------------
module irq_ctrl (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic       ioreq_n,
    input  logic [3:0] reg_addr_i,
    input  logic [7:0] data_i,
    input  logic       irq_cs,
    input  logic [3:0] irq_src_i,
    output logic [7:0] data_o,
    output logic       vec_oe_o,
    output logic       int_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] IDX_NONE = 3'd7;

    // Highest-priority (lowest index) set bit, or IDX_NONE when empty.
    function automatic logic [2:0] prio_idx(input logic [4:0] req);
        logic [2:0] idx;
        casez (req)
            5'b????1: idx = 3'd0;
            5'b???10: idx = 3'd1;
            5'b??100: idx = 3'd2;
            5'b?1000: idx = 3'd3;
            5'b10000: idx = 3'd4;
            default:  idx = IDX_NONE;
        endcase
        return idx;
    endfunction

    // state
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  prev_q,  prev_d;
    logic [1:0]  arm_q,   arm_d;
    logic [4:0]  pend_q,  pend_d;
    logic [7:0]  en_q,    en_d;
    logic [7:0]  vbase_q, vbase_d;
    logic [7:0]  div_l_q, div_l_d;
    logic [7:0]  div_h_q, div_h_d;
    logic        tctrl_q, tctrl_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [7:0]  snap_q,  snap_d;
    state_e      state_q, state_d;
    logic [2:0]  idx_q,   idx_d;
    logic        int_n_q, int_n_d;

    // combinational helpers
    logic        wr_en_s;
    logic        rd_en_s;
    logic [15:0] div_s;
    logic [3:0]  edge_s;
    logic        tick_s;
    logic [4:0]  clr_s;
    logic [4:0]  set_s;
    logic [7:0]  rd_data_s;

    assign wr_en_s = irq_cs & ~wr_n & ~ioreq_n;
    // An acknowledge cycle is not a register read.
    assign rd_en_s = irq_cs & wr_n & ~ioreq_n & m1_n;
    assign div_s   = {div_h_q, div_l_q};

    // Input synchronisers and rising-edge detect. Edges are ignored until the
    // pipeline has been refilled after reset, so lines already high at reset
    // release are not mistaken for edges.
    always_comb begin
        sync1_d = irq_src_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (arm_q == 2'd3) begin
            arm_d  = arm_q;
            edge_s = sync2_q & ~prev_q;
        end else begin
            arm_d  = arm_q + 2'd1;
            edge_s = 4'b0000;
        end
    end

    // Register writes and the CNT_H snapshot.
    always_comb begin
        en_d    = en_q;
        vbase_d = vbase_q;
        div_l_d = div_l_q;
        div_h_d = div_h_q;
        tctrl_d = tctrl_q;
        snap_d  = snap_q;
        if (wr_en_s) begin
            case (reg_addr_i)
                4'd1:    en_d    = data_i & 8'h9F;
                4'd2:    vbase_d = data_i;
                4'd3:    div_l_d = data_i;
                4'd4:    div_h_d = data_i;
                4'd5:    tctrl_d = data_i[0];
                default: en_d    = en_q;
            endcase
        end else begin
            en_d = en_q;
        end
        // Snapshot the high byte alongside the low byte the CPU is reading.
        if (rd_en_s && (reg_addr_i == 4'd6)) begin
            snap_d = cnt_q[15:8];
        end else begin
            snap_d = snap_q;
        end
    end

    // Timer: DIV_H write loads, otherwise count down and reload at 1.
    always_comb begin
        cnt_d  = cnt_q;
        tick_s = 1'b0;
        if (wr_en_s && (reg_addr_i == 4'd4)) begin
            cnt_d = {data_i, div_l_q};
        end else if (tctrl_q && (div_s != 16'h0000)) begin
            // A counter left at 0 (DIV changed without a DIV_H write)
            // reloads silently instead of wrapping through 0xFFFF.
            if (cnt_q <= 16'h0001) begin
                cnt_d  = div_s;
                tick_s = (cnt_q == 16'h0001);
            end else begin
                cnt_d = cnt_q - 16'h0001;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pending bits: sets take precedence over W1C and acknowledge clears.
    always_comb begin
        clr_s = 5'b00000;
        set_s = {edge_s, tick_s};
        if (wr_en_s && (reg_addr_i == 4'd0)) begin
            clr_s = data_i[4:0];
        end else begin
            clr_s = 5'b00000;
        end
        if ((state_q == ST_DONE) && (idx_q != IDX_NONE)) begin
            clr_s = clr_s | (5'b00001 << idx_q);
        end else begin
            clr_s = clr_s;
        end
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    // Acknowledge FSM next state and the registered int_n request.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (!m1_n && !ioreq_n) begin
                    state_d = ST_ACK;
                    idx_d   = prio_idx(pend_q & en_q[4:0] & {5{en_q[7]}});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (m1_n || ioreq_n) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        int_n_d = ~(en_q[7] && ((pend_q & en_q[4:0]) != 5'b00000)
                    && (state_q == ST_IDLE));
    end

    // Register read mux; vector overrides it during acknowledge.
    always_comb begin
        case (reg_addr_i)
            4'd0:    rd_data_s = {3'b000, pend_q};
            4'd1:    rd_data_s = en_q;
            4'd2:    rd_data_s = vbase_q;
            4'd3:    rd_data_s = div_l_q;
            4'd4:    rd_data_s = div_h_q;
            4'd5:    rd_data_s = {7'b0000000, tctrl_q};
            4'd6:    rd_data_s = cnt_q[7:0];
            4'd7:    rd_data_s = snap_q;
            default: rd_data_s = 8'h00;
        endcase
        if (state_q == ST_ACK) begin
            data_o = {vbase_q[7:4], idx_q, 1'b0};
        end else begin
            data_o = rd_data_s;
        end
    end

    assign vec_oe_o = (state_q == ST_ACK);
    assign int_n    = int_n_q;

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            prev_q  <= 4'b0000;
            arm_q   <= 2'd0;
            pend_q  <= 5'b00000;
            en_q    <= 8'h00;
            vbase_q <= 8'h00;
            div_l_q <= 8'h00;
            div_h_q <= 8'h00;
            tctrl_q <= 1'b0;
            cnt_q   <= 16'h0000;
            snap_q  <= 8'h00;
            state_q <= ST_IDLE;
            idx_q   <= IDX_NONE;
            int_n_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            vbase_q <= vbase_d;
            div_l_q <= div_l_d;
            div_h_q <= div_h_d;
            tctrl_q <= tctrl_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            int_n_q <= int_n_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- directed self-checking bench for irq_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       wr_n = 1'b1;
    logic       m1_n = 1'b1;
    logic       ioreq_n = 1'b1;
    logic [3:0] reg_addr_i = 4'd0;
    logic [7:0] data_i = 8'h00;
    logic       irq_cs = 1'b0;
    logic [3:0] irq_src_i = 4'b0000;
    logic [7:0] data_o;
    logic       vec_oe_o;
    logic       int_n;

    int total = 0;
    int bad = 0;

    irq_ctrl dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .ioreq_n    (ioreq_n),
        .reg_addr_i (reg_addr_i),
        .data_i     (data_i),
        .irq_cs     (irq_cs),
        .irq_src_i  (irq_src_i),
        .data_o     (data_o),
        .vec_oe_o   (vec_oe_o),
        .int_n      (int_n)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        irq_cs = 1'b1; ioreq_n = 1'b0; wr_n = 1'b0; reg_addr_i = a; data_i = d;
        step();
        irq_cs = 1'b0; ioreq_n = 1'b1; wr_n = 1'b1;
    endtask

    // Combinational read with no clock edge.
    task automatic peek(input logic [3:0] a, output logic [7:0] v);
        irq_cs = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; reg_addr_i = a;
        #1;
        v = data_o;
        irq_cs = 1'b0; ioreq_n = 1'b1;
    endtask

    // Read spanning one clock edge (exercises the CNT_L snapshot).
    task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
        irq_cs = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; reg_addr_i = a;
        #1;
        v = data_o;
        step();
        irq_cs = 1'b0; ioreq_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL reset_int_n got=%b exp=1", int_n); end
        total++; if (vec_oe_o !== 1'b0) begin bad++; $display("FAIL reset_vec_oe got=%b exp=0", vec_oe_o); end
        for (int a = 0; a < 10; a++) begin
            peek(4'(a), v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_reg%0d got=%h exp=00", a, v); end
        end
    endtask

    task automatic test_regs();
        logic [7:0] v;
        wr_reg(4'd2, 8'h3C); peek(4'd2, v);
        total++; if (v !== 8'h3C) begin bad++; $display("FAIL vbase_rw got=%h exp=3c", v); end
        wr_reg(4'd1, 8'hFF); peek(4'd1, v);
        total++; if (v !== 8'h9F) begin bad++; $display("FAIL enable_mask got=%h exp=9f", v); end
        wr_reg(4'd5, 8'hFF); peek(4'd5, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL tctrl_mask got=%h exp=01", v); end
        wr_reg(4'd3, 8'h5A); peek(4'd3, v);
        total++; if (v !== 8'h5A) begin bad++; $display("FAIL divl_rw got=%h exp=5a", v); end
        wr_reg(4'd3, 8'h00);
        // DIV=0 with the timer running: no events
        repeat (4) step();
        peek(4'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL div0_no_event got=%h exp=00", v); end
        // high addresses read zero and do not alias onto 0-7
        wr_reg(4'd10, 8'h55); peek(4'd2, v);
        total++; if (v !== 8'h3C) begin bad++; $display("FAIL hi_addr_alias got=%h exp=3c", v); end
        peek(4'd10, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL hi_addr_read got=%h exp=00", v); end
        wr_reg(4'd5, 8'h00);
        wr_reg(4'd1, 8'h00);
    endtask

    task automatic test_timer();
        logic [7:0] v;
        wr_reg(4'd3, 8'h04);
        wr_reg(4'd4, 8'h00);   // counter = 4
        wr_reg(4'd1, 8'h81);
        wr_reg(4'd5, 8'h01);   // run; counter still 4 after this edge
        for (int k = 1; k <= 4; k++) begin
            step();
            peek(4'd0, v);
            total++;
            if (v !== ((k == 4) ? 8'h01 : 8'h00)) begin
                bad++; $display("FAIL timer_first_set k=%0d got=%h exp=%h", k, v, (k == 4) ? 8'h01 : 8'h00);
            end
        end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL timer_int_latency got=%b exp=1", int_n); end
        step();
        total++; if (int_n !== 1'b0) begin bad++; $display("FAIL timer_int_assert got=%b exp=0", int_n); end
        wr_reg(4'd0, 8'h01);   // clear lands two edges after the set
        peek(4'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL timer_w1c got=%h exp=00", v); end
        step(); peek(4'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL timer_period_early got=%h exp=00", v); end
        step(); peek(4'd0, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL timer_period got=%h exp=01", v); end
        wr_reg(4'd5, 8'h00);
        wr_reg(4'd0, 8'h1F);
        wr_reg(4'd1, 8'h00);
        step();
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL timer_int_release got=%b exp=1", int_n); end
    endtask

    task automatic test_ack();
        logic [7:0] v;
        wr_reg(4'd2, 8'hA0);
        wr_reg(4'd1, 8'h8A);
        irq_src_i = 4'b0101;   // sources 1 and 3
        repeat (4) step();
        peek(4'd0, v);
        total++; if (v !== 8'h0A) begin bad++; $display("FAIL ack_pending_in got=%h exp=0a", v); end
        total++; if (int_n !== 1'b0) begin bad++; $display("FAIL ack_int_before got=%b exp=0", int_n); end
        m1_n = 1'b0; ioreq_n = 1'b0;
        step();
        total++; if (vec_oe_o !== 1'b1) begin bad++; $display("FAIL ack_vec_oe got=%b exp=1", vec_oe_o); end
        total++; if (data_o !== 8'hA2) begin bad++; $display("FAIL ack_vector got=%h exp=a2", data_o); end
        // ENABLE change inside ACK must not move the latched index
        irq_cs = 1'b1; wr_n = 1'b0; reg_addr_i = 4'd1; data_i = 8'h88;
        step();
        irq_cs = 1'b0; wr_n = 1'b1;
        total++; if (data_o !== 8'hA2) begin bad++; $display("FAIL ack_idx_stable got=%h exp=a2", data_o); end
        m1_n = 1'b1; ioreq_n = 1'b1;
        step();
        total++; if (vec_oe_o !== 1'b0) begin bad++; $display("FAIL ack_end_vec_oe got=%b exp=0", vec_oe_o); end
        step(); step();
        peek(4'd0, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL ack_pending_after got=%h exp=08", v); end
        total++; if (int_n !== 1'b0) begin bad++; $display("FAIL ack_int_after got=%b exp=0", int_n); end
        irq_src_i = 4'b0000;
    endtask

    task automatic test_spurious();
        logic [7:0] v;
        wr_reg(4'd1, 8'h00);
        m1_n = 1'b0; ioreq_n = 1'b0;
        step();
        total++; if (data_o !== 8'hAE) begin bad++; $display("FAIL spur_vector got=%h exp=ae", data_o); end
        total++; if (vec_oe_o !== 1'b1) begin bad++; $display("FAIL spur_vec_oe got=%b exp=1", vec_oe_o); end
        m1_n = 1'b1; ioreq_n = 1'b1;
        step(); step();
        peek(4'd0, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL spur_pending got=%h exp=08", v); end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL spur_int got=%b exp=1", int_n); end
    endtask

    task automatic test_set_wins();
        logic [7:0] v;
        step(); step();
        irq_src_i = 4'b0001;
        step(); step();          // synchronised edge is now visible
        wr_reg(4'd0, 8'h02);     // W1C of bit 1 on the same edge as its set
        peek(4'd0, v);
        total++; if (v !== 8'h0A) begin bad++; $display("FAIL set_wins got=%h exp=0a", v); end
        wr_reg(4'd0, 8'h02);
        peek(4'd0, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL w1c_select got=%h exp=08", v); end
        wr_reg(4'd0, 8'h08);
        peek(4'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL w1c_all got=%h exp=00", v); end
        irq_src_i = 4'b0000;
    endtask

    task automatic test_snapshot();
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] v;
        wr_reg(4'd3, 8'h01);
        wr_reg(4'd4, 8'h13);     // counter = 0x1301
        wr_reg(4'd5, 8'h01);     // run; counter holds on this edge
        step();                  // 0x1300
        rd_reg(4'd6, lo);        // high byte latched as counter steps to 0x12FF
        rd_reg(4'd7, hi);
        total++; if ({hi, lo} !== 16'h1300) begin bad++; $display("FAIL snapshot got=%h exp=1300", {hi, lo}); end
        peek(4'd6, v);           // counter is now 0x12FE
        total++; if (v !== 8'hFE) begin bad++; $display("FAIL count_down got=%h exp=fe", v); end
        wr_reg(4'd5, 8'h00);
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] v;
        wr_reg(4'd2, 8'hA0);
        wr_reg(4'd1, 8'h84);
        wr_reg(4'd3, 8'h55);
        irq_src_i = 4'b0010;     // source 2
        repeat (4) step();
        m1_n = 1'b0; ioreq_n = 1'b0;
        step();
        total++; if (data_o !== 8'hA4) begin bad++; $display("FAIL rst_ack_vector got=%h exp=a4", data_o); end
        #1 rst_n_i = 1'b0;
        #1;
        total++; if (vec_oe_o !== 1'b0) begin bad++; $display("FAIL rst_ack_vec_oe got=%b exp=0", vec_oe_o); end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL rst_ack_int got=%b exp=1", int_n); end
        m1_n = 1'b1; ioreq_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            peek(4'(a), v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL rst_ack_reg%0d got=%h exp=00", a, v); end
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;          // irq_src_i[1] still high: must not count as an edge
        repeat (5) step();
        peek(4'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL rst_level_no_edge got=%h exp=00", v); end
        total++; if (vec_oe_o !== 1'b0) begin bad++; $display("FAIL rst_after_vec_oe got=%b exp=0", vec_oe_o); end
        irq_src_i = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_timer();
        test_ack();
        test_spurious();
        test_set_wins();
        test_snapshot();
        test_reset_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
